// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: loads a word, shifts it one bit per clock for a programmable
// count in logical, arithmetic or rotate mode, with a start/busy/done handshake.
module seq_shifter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [AW-1:0]    amt,
  input  logic [2:0]       mode,
  input  logic             sin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             sout
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_dout;
  logic [AW-1:0]    r_count;
  logic [2:0]       r_mode;
  logic             r_sin;
  logic             r_sout;

  logic [WIDTH-1:0] w_shift_dout;
  logic             w_shift_sout;

  // One-bit step of the working register; reserved modes leave it untouched.
  always_comb begin
    w_shift_dout = r_dout;
    w_shift_sout = r_sout;
    case (r_mode)
      MODE_LSL: begin
        w_shift_dout = {r_dout[WIDTH-2:0], r_sin};
        w_shift_sout = r_dout[WIDTH-1];
      end
      MODE_LSR: begin
        w_shift_dout = {r_sin, r_dout[WIDTH-1:1]};
        w_shift_sout = r_dout[0];
      end
      MODE_ASR: begin
        w_shift_dout = {r_dout[WIDTH-1], r_dout[WIDTH-1:1]};
        w_shift_sout = r_dout[0];
      end
      MODE_ROL: begin
        w_shift_dout = {r_dout[WIDTH-2:0], r_dout[WIDTH-1]};
        w_shift_sout = r_dout[WIDTH-1];
      end
      MODE_ROR: begin
        w_shift_dout = {r_dout[0], r_dout[WIDTH-1:1]};
        w_shift_sout = r_dout[0];
      end
      default: begin
        w_shift_dout = r_dout;
        w_shift_sout = r_sout;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_dout  <= '0;
      r_count <= '0;
      r_mode  <= '0;
      r_sin   <= 1'b0;
      r_sout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_dout  <= din;
            r_count <= amt;
            r_mode  <= mode;
            r_sin   <= sin;
            r_sout  <= 1'b0;
            r_state <= (amt != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          r_dout  <= w_shift_dout;
          r_sout  <= w_shift_sout;
          r_count <= r_count - AW'(1);
          if (r_count == AW'(1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign dout = r_dout;
  assign sout = r_sout;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed handshake/reset scenarios plus randomized
// operations checked against an arithmetic reference model.
module tb_seq_shifter;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  din;
  logic [AW-1:0] amt;
  logic [2:0]    mode;
  logic          sin;
  logic          busy;
  logic          done;
  logic [W-1:0]  dout;
  logic          sout;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  seq_shifter #(
    .WIDTH(W),
    .AW   (AW)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .din  (din),
    .amt  (amt),
    .mode (mode),
    .sin  (sin),
    .busy (busy),
    .done (done),
    .dout (dout),
    .sout (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Whole-operation result from plain arithmetic; returns {sout, dout}.
  function automatic logic [8:0] model(input int m, input int d, input int n, input int s);
    int r;
    int so;
    r  = d;
    so = 0;
    if (n != 0 && m <= 4) begin
      case (m)
        0: begin
          r  = ((d << n) | (s != 0 ? (1 << n) - 1 : 0)) & 255;
          so = (d >> (8 - n)) & 1;
        end
        1: begin
          r  = (d >> n) | (s != 0 ? (255 & ~(255 >> n)) : 0);
          so = (d >> (n - 1)) & 1;
        end
        2: begin
          r  = (d >> n) | ((d & 128) != 0 ? (255 & ~(255 >> n)) : 0);
          so = (d >> (n - 1)) & 1;
        end
        3: begin
          r  = ((d << n) | (d >> (8 - n))) & 255;
          so = r & 1;
        end
        default: begin
          r  = ((d >> n) | (d << (8 - n))) & 255;
          so = (r >> 7) & 1;
        end
      endcase
    end
    model = {so[0], r[7:0]};
  endfunction

  // Start one operation and verify latency, busy span, result, and return to idle.
  task automatic do_op(input string tag, input int m, input int d, input int n, input int s);
    logic [8:0] exp;
    int cycles;
    int busy_cnt;
    exp = model(m, d, n, s);
    @(negedge clk);
    start = 1'b1;
    mode  = m[2:0];
    din   = d[7:0];
    amt   = n[2:0];
    sin   = s[0];
    @(posedge clk);
    #1;
    start    = 1'b0;
    din      = 8'h00;
    amt      = 3'd1;
    cycles   = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles <= 20) begin
      @(posedge clk);
      #1;
      cycles++;
      busy_cnt += busy ? 1 : 0;
    end
    check_eq({tag, " latency"}, cycles, n + 1);
    check_eq({tag, " busy_cycles"}, busy_cnt, n + 1);
    check_eq({tag, " dout"}, {24'h0, dout}, {24'h0, exp[7:0]});
    check_eq({tag, " sout"}, {31'h0, sout}, {31'h0, exp[8]});
    @(posedge clk);
    #1;
    check_eq({tag, " idle_busy"}, {31'h0, busy}, 32'h0);
    check_eq({tag, " idle_done"}, {31'h0, done}, 32'h0);
    check_eq({tag, " hold_dout"}, {24'h0, dout}, {24'h0, exp[7:0]});
  endtask

  initial begin
    int done_cnt;
    int t_done[$];
    logic [8:0] exp;

    rst   = 1'b1;
    start = 1'b0;
    din   = 8'h00;
    amt   = 3'd0;
    mode  = 3'd0;
    sin   = 1'b0;
    #1;
    check_eq("reset dout", {24'h0, dout}, 32'h0);
    check_eq("reset busy", {31'h0, busy}, 32'h0);
    check_eq("reset done", {31'h0, done}, 32'h0);
    check_eq("reset sout", {31'h0, sout}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op("lsl96", 0, 'h96, 3, 0);
    do_op("lsr0f", 1, 'h0F, 4, 1);
    do_op("asr84", 2, 'h84, 2, 0);
    do_op("ror81", 4, 'h81, 1, 0);
    for (int m = 0; m < 8; m++) do_op("amt0", m, 'h5A, 0, 1);
    do_op("rsvd", 6, 'h3C, 5, 1);

    // ROL A5 by 7 with start pulses during SHIFT and during DONE.
    @(negedge clk);
    start = 1'b1; mode = 3'd3; din = 8'hA5; amt = 3'd7; sin = 1'b0;
    @(negedge clk);
    start = 1'b0; din = 8'h00; amt = 3'd1;
    done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      start = (i == 2) || (i >= 1 && done);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) done_cnt++;
      @(negedge clk);
    end
    check_eq("ign dout", {24'h0, dout}, 32'hD2);
    check_eq("ign sout", {31'h0, sout}, 32'h0);
    check_eq("ign done_pulses", done_cnt, 1);
    check_eq("ign busy_after", {31'h0, busy}, 32'h0);

    // Asynchronous reset mid-cycle during an LSL shift.
    @(negedge clk);
    start = 1'b1; mode = 3'd0; din = 8'hFF; amt = 3'd5; sin = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst dout", {24'h0, dout}, 32'h0);
    check_eq("arst busy", {31'h0, busy}, 32'h0);
    check_eq("arst done", {31'h0, done}, 32'h0);
    check_eq("arst sout", {31'h0, sout}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check_eq("arst no_done", done_cnt, 0);
    do_op("post_rst", 0, 'h01, 1, 0);

    // start held high: accepts only from IDLE, one op every 4 cycles.
    exp = model(0, 'h03, 2, 0);
    mode = 3'd0; amt = 3'd2; sin = 1'b0;
    for (int i = 0; i < 20 && t_done.size() < 3; i++) begin
      @(negedge clk);
      start = 1'b1;
      if (busy) begin
        din = 8'($urandom);
        amt = 3'($urandom);
      end else begin
        din = 8'h03;
        amt = 3'd2;
      end
      @(posedge clk);
      #1;
      if (done) begin
        t_done.push_back(cyc);
        check_eq("hold dout", {24'h0, dout}, {24'h0, exp[7:0]});
      end
    end
    @(negedge clk);
    start = 1'b0;
    check_eq("hold done_count", t_done.size(), 3);
    for (int i = 1; i < t_done.size(); i++) begin
      check_eq("hold spacing", t_done[i] - t_done[i-1], 4);
    end
    repeat (3) @(negedge clk);

    for (int k = 0; k < 60; k++) begin
      do_op("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
